// File: rtl/regfile_pkg.sv
// Shared constants for the multi-port register file.
package regfile_pkg;

  localparam int unsigned DATA_W_DEFAULT = 32;
  localparam int unsigned ADDR_W_DEFAULT = 5;

  // Architectural register numbers.
  localparam int unsigned REG_ZERO = 0;
  // Link register, targeted by the decode destination mux.
  localparam int unsigned REG_RA   = 31;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending-write scoreboard. A write-back clears the busy bit and an issue sets it.
// When both happen to one register in the same cycle, the issue wins because it names a newer
// producer.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W         = ADDR_W_DEFAULT,
  parameter bit          ZERO_HARDWIRED = 1'b1
) (
  input  logic                   CLK,
  input  logic                   Reset,
  input  logic                   IssueValid,
  input  logic [ADDR_W-1:0]      IssueAddr,
  input  logic                   WE0,
  input  logic [ADDR_W-1:0]      WAddr0,
  input  logic                   WE1,
  input  logic [ADDR_W-1:0]      WAddr1,
  output logic [2**ADDR_W-1:0]   BusyVec
);

  localparam int unsigned NREG = 2**ADDR_W;

  logic [NREG-1:0] busy_q, busy_d;

  // Next busy state: clear on write-back first, then let an issue override.
  always_comb begin
    busy_d = busy_q;
    for (int n = 0; n < NREG; n++) begin
      if ((WE0 && (WAddr0 == ADDR_W'(n))) || (WE1 && (WAddr1 == ADDR_W'(n)))) begin
        busy_d[n] = 1'b0;
      end
      if (IssueValid && (IssueAddr == ADDR_W'(n))) begin
        busy_d[n] = 1'b1;
      end
    end
    if (ZERO_HARDWIRED) begin
      busy_d[REG_ZERO] = 1'b0;
    end
  end

  // Busy-bit register.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign BusyVec = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NRD combinational read ports with write-to-read bypass, two
// prioritised write-back ports (port 0 wins), a pending-write scoreboard and a sticky
// write-conflict flag.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W         = DATA_W_DEFAULT,
  parameter int unsigned ADDR_W         = ADDR_W_DEFAULT,
  parameter int unsigned NRD            = 3,
  parameter bit          ZERO_HARDWIRED = 1'b1
) (
  input  logic                   CLK,
  input  logic                   Reset,
  input  logic [NRD*ADDR_W-1:0]  RAddr,
  output logic [NRD*DATA_W-1:0]  RData,
  output logic [NRD-1:0]         RBusy,
  input  logic                   WE0,
  input  logic [ADDR_W-1:0]      WAddr0,
  input  logic [DATA_W-1:0]      WData0,
  input  logic                   WE1,
  input  logic [ADDR_W-1:0]      WAddr1,
  input  logic [DATA_W-1:0]      WData1,
  input  logic                   IssueValid,
  input  logic [ADDR_W-1:0]      IssueAddr,
  output logic [2**ADDR_W-1:0]   BusyVec,
  output logic                   WriteConflict
);

  localparam int unsigned NREG = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZeroAddr = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] mem_q [NREG];
  logic [DATA_W-1:0] mem_d [NREG];
  logic              conflict_q, conflict_d;
  logic              we0_eff, we1_eff;

  // Writes that actually land in the array (r0 is read-only when hardwired).
  assign we0_eff = WE0 && !(ZERO_HARDWIRED && (WAddr0 == ZeroAddr));
  assign we1_eff = WE1 && !(ZERO_HARDWIRED && (WAddr1 == ZeroAddr));

  // Array next state: port 1 first so that port 0 overwrites it on an address clash.
  always_comb begin
    mem_d = mem_q;
    if (we1_eff) mem_d[WAddr1] = WData1;
    if (we0_eff) mem_d[WAddr0] = WData0;
  end

  // Conflict flag is sticky until reset; r0 clashes are never a conflict.
  always_comb begin
    conflict_d = conflict_q;
    if (WE0 && WE1 && (WAddr0 == WAddr1) && (WAddr0 != ZeroAddr)) begin
      conflict_d = 1'b1;
    end
  end

  // Storage array and conflict flag.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      for (int n = 0; n < NREG; n++) begin
        mem_q[n] <= '0;
      end
      conflict_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      conflict_q <= conflict_d;
    end
  end

  assign WriteConflict = conflict_q;

  rf_scoreboard #(
    .ADDR_W         (ADDR_W),
    .ZERO_HARDWIRED (ZERO_HARDWIRED)
  ) u_scoreboard (
    .CLK        (CLK),
    .Reset      (Reset),
    .IssueValid (IssueValid),
    .IssueAddr  (IssueAddr),
    .WE0        (WE0),
    .WAddr0     (WAddr0),
    .WE1        (WE1),
    .WAddr1     (WAddr1),
    .BusyVec    (BusyVec)
  );

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [ADDR_W-1:0] raddr;
    logic [DATA_W-1:0] rdata;
    logic              hit0, hit1;

    assign raddr = RAddr[i*ADDR_W +: ADDR_W];
    assign hit0  = WE0 && (WAddr0 == raddr);
    assign hit1  = WE1 && (WAddr1 == raddr);

    // Read mux: forced zero in reset and for hardwired r0, then bypass, then array.
    always_comb begin
      if (!Reset || (ZERO_HARDWIRED && (raddr == ZeroAddr))) begin
        rdata = '0;
      end else if (hit0) begin
        rdata = WData0;
      end else if (hit1) begin
        rdata = WData1;
      end else begin
        rdata = mem_q[raddr];
      end
    end

    assign RData[i*DATA_W +: DATA_W] = rdata;
    // An operand being written this cycle is bypassed, so it is never reported busy.
    assign RBusy[i] = BusyVec[raddr] && !(hit0 || hit1);
  end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;
  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NR   = 3;
  localparam int NREG = 32;

  logic               CLK = 1'b0;
  logic               Reset;
  logic [NR*AW-1:0]   RAddr;
  logic [NR*DW-1:0]   RData;
  logic [NR-1:0]      RBusy;
  logic               WE0, WE1, IssueValid;
  logic [AW-1:0]      WAddr0, WAddr1, IssueAddr;
  logic [DW-1:0]      WData0, WData1;
  logic [NREG-1:0]    BusyVec;
  logic               WriteConflict;

  regfile_mp #(
    .DATA_W         (DW),
    .ADDR_W         (AW),
    .NRD            (NR),
    .ZERO_HARDWIRED (1'b1)
  ) dut (
    .CLK           (CLK),
    .Reset         (Reset),
    .RAddr         (RAddr),
    .RData         (RData),
    .RBusy         (RBusy),
    .WE0           (WE0),
    .WAddr0        (WAddr0),
    .WData0        (WData0),
    .WE1           (WE1),
    .WAddr1        (WAddr1),
    .WData1        (WData1),
    .IssueValid    (IssueValid),
    .IssueAddr     (IssueAddr),
    .BusyVec       (BusyVec),
    .WriteConflict (WriteConflict)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Scoreboard of expected values, pushed when stimulus is driven.
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got, exp;

  // Reference state.
  logic [DW-1:0]   m_mem [NREG];
  logic [NREG-1:0] m_busy;
  logic            m_conf;

  task automatic model_clear();
    for (int n = 0; n < NREG; n++) m_mem[n] = '0;
    m_busy = '0;
    m_conf = 1'b0;
  endtask

  // Apply the current inputs to the model, then advance to just after the next edge.
  task automatic tick();
    if (Reset) begin
      if (WE0 && WE1 && WAddr0 == WAddr1 && WAddr0 != 0) m_conf = 1'b1;
      if (WE1 && WAddr1 != 0) m_mem[WAddr1] = WData1;
      if (WE0 && WAddr0 != 0) m_mem[WAddr0] = WData0;
      if (WE0) m_busy[WAddr0] = 1'b0;
      if (WE1) m_busy[WAddr1] = 1'b0;
      if (IssueValid && IssueAddr != 0) m_busy[IssueAddr] = 1'b1;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    WE0 = 0; WE1 = 0; IssueValid = 0;
  endtask

  task automatic set_ra(input int p, input logic [AW-1:0] a);
    RAddr[p*AW +: AW] = a;
  endtask

  function automatic logic [DW-1:0] rd(input int p);
    return RData[p*DW +: DW];
  endfunction

  task automatic test_reset();
    Reset = 0; idle(); RAddr = '0;
    WAddr0 = 0; WAddr1 = 0; IssueAddr = 0; WData0 = 0; WData1 = 0;
    model_clear();
    // Bypass must not leak through while in reset.
    WE0 = 1; WAddr0 = 1; WData0 = 32'hCAFE0001; set_ra(0, 1);
    #2;
    exp_q.push_back(32'h0);
    got = rd(0); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL reset_rdata got=%h exp=%h", got, exp); end
    checks++;
    if (BusyVec !== '0 || WriteConflict !== 1'b0) begin
      errors++; $display("FAIL reset_state busy=%h wc=%b exp 0/0", BusyVec, WriteConflict);
    end
    idle();
    @(negedge CLK); Reset = 1;
    tick();
    WE0 = 1; WAddr0 = 5; WData0 = 32'hDEADBEEF;
    WE1 = 1; WAddr1 = 5; WData1 = 32'h12345678;
    IssueValid = 1; IssueAddr = 5;
    tick(); idle(); set_ra(0, 5);
    exp_q.push_back(32'hDEADBEEF);
    #1;
    got = rd(0); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL pre_reset_r5 got=%h exp=%h", got, exp); end
    checks++;
    if (BusyVec[5] !== 1'b1 || WriteConflict !== 1'b1) begin
      errors++; $display("FAIL pre_reset_state busy5=%b wc=%b exp 1/1", BusyVec[5], WriteConflict);
    end
    #2; Reset = 0; model_clear();
    exp_q.push_back(32'h0);
    #1;
    got = rd(0); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL midcycle_reset_r5 got=%h exp=%h", got, exp); end
    checks++;
    if (BusyVec !== '0 || WriteConflict !== 1'b0) begin
      errors++; $display("FAIL midcycle_reset_state busy=%h wc=%b exp 0/0", BusyVec, WriteConflict);
    end
    @(negedge CLK); Reset = 1;
    tick();
  endtask

  task automatic test_bypass();
    set_ra(0, 2); WE0 = 1; WAddr0 = 2; WData0 = 32'h1;
    set_ra(1, 6); WE1 = 1; WAddr1 = 6; WData1 = 32'hB;
    exp_q.push_back(32'h1); exp_q.push_back(32'hB);
    #1;
    got = rd(0); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL bypass_p0 got=%h exp=%h", got, exp); end
    got = rd(1); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL bypass_p1 got=%h exp=%h", got, exp); end
    tick(); idle();
    exp_q.push_back(32'h1); exp_q.push_back(32'hB);
    #1;
    got = rd(0); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL stored_r2 got=%h exp=%h", got, exp); end
    got = rd(1); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL stored_r6 got=%h exp=%h", got, exp); end
  endtask

  task automatic test_zero();
    WE1 = 1; WAddr1 = 0; WData1 = 32'hFFFFFFFF; IssueValid = 1; IssueAddr = 0;
    set_ra(0, 0); set_ra(1, 0); set_ra(2, 0);
    exp_q.push_back(32'h0);
    #1;
    got = rd(1); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL r0_bypass got=%h exp=%h", got, exp); end
    tick(); idle();
    exp_q.push_back(32'h0);
    #1;
    got = rd(0); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL r0_stored got=%h exp=%h", got, exp); end
    checks++;
    if (BusyVec[0] !== 1'b0 || RBusy !== 3'b000) begin
      errors++; $display("FAIL r0_busy busy0=%b rbusy=%b exp 0/000", BusyVec[0], RBusy);
    end
  endtask

  task automatic test_conflict();
    WE0 = 1; WAddr0 = 7; WData0 = 32'h11; WE1 = 1; WAddr1 = 7; WData1 = 32'h22;
    set_ra(0, 7);
    exp_q.push_back(32'h11);
    #1;
    got = rd(0); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL dual_bypass_r7 got=%h exp=%h", got, exp); end
    checks++;
    if (WriteConflict !== 1'b0) begin
      errors++; $display("FAIL conflict_early got=%b exp=0", WriteConflict);
    end
    tick(); idle();
    exp_q.push_back(32'h11);
    #1;
    got = rd(0); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL conflict_r7 got=%h exp=%h", got, exp); end
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (WriteConflict !== 1'b1) begin
        errors++; $display("FAIL conflict_sticky cycle=%0d got=%b exp=1", c, WriteConflict);
      end
      tick();
    end
  endtask

  task automatic test_scoreboard();
    IssueValid = 1; IssueAddr = 9;
    tick(); idle(); set_ra(1, 9);
    #1;
    checks++;
    if (BusyVec[9] !== 1'b1 || RBusy[1] !== 1'b1) begin
      errors++; $display("FAIL sb_issue busy9=%b rbusy1=%b exp 1/1", BusyVec[9], RBusy[1]);
    end
    WE1 = 1; WAddr1 = 9; WData1 = 32'h44;
    exp_q.push_back(32'h44);
    #1;
    checks++;
    if (RBusy[1] !== 1'b0) begin errors++; $display("FAIL sb_bypass_rbusy got=%b exp=0", RBusy[1]); end
    got = rd(1); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL sb_bypass_data got=%h exp=%h", got, exp); end
    tick(); idle();
    #1;
    checks++;
    if (BusyVec[9] !== 1'b0) begin errors++; $display("FAIL sb_clear got=%b exp=0", BusyVec[9]); end
  endtask

  task automatic test_set_wins();
    IssueValid = 1; IssueAddr = 9;
    tick();
    WE0 = 1; WAddr0 = 9; WData0 = 32'h55;
    tick(); idle(); set_ra(1, 9);
    exp_q.push_back(32'h55);
    #1;
    got = rd(1); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL setwins_data got=%h exp=%h", got, exp); end
    checks++;
    if (BusyVec[9] !== 1'b1) begin errors++; $display("FAIL setwins_busy got=%b exp=1", BusyVec[9]); end
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    return ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
  endfunction

  task automatic test_random();
    logic [AW-1:0] a;
    logic          h;
    for (int c = 0; c < 300; c++) begin
      WE0 = 1'($urandom_range(0, 1)); WAddr0 = rnd_addr(); WData0 = $urandom;
      WE1 = 1'($urandom_range(0, 1)); WAddr1 = rnd_addr(); WData1 = $urandom;
      IssueValid = 1'($urandom_range(0, 1)); IssueAddr = rnd_addr();
      for (int p = 0; p < NR; p++) begin
        a = rnd_addr(); set_ra(p, a);
        h = (WE0 && WAddr0 == a) || (WE1 && WAddr1 == a);
        if (a == 0) exp_q.push_back(32'h0);
        else if (WE0 && WAddr0 == a) exp_q.push_back(WData0);
        else if (WE1 && WAddr1 == a) exp_q.push_back(WData1);
        else exp_q.push_back(m_mem[a]);
        exp_q.push_back(DW'(m_busy[a] && !h));
      end
      #1;
      for (int p = 0; p < NR; p++) begin
        got = rd(p); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL rand_rdata c=%0d p=%0d got=%h exp=%h", c, p, got, exp); end
        got = DW'(RBusy[p]); exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL rand_rbusy c=%0d p=%0d got=%0d exp=%0d", c, p, got, exp); end
      end
      checks++;
      if (BusyVec !== m_busy || WriteConflict !== m_conf) begin
        errors++;
        $display("FAIL rand_state c=%0d busy=%h exp=%h wc=%b exp=%b", c, BusyVec, m_busy, WriteConflict, m_conf);
      end
      tick();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_zero();
    test_conflict();
    test_scoreboard();
    test_set_wins();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
